// File: rtl/register_file_8x.sv
// register_file_8x: eight DATA_W-bit registers with a one-hot write port,
// two registered read ports, a sticky error flag for illegal (multi-hot)
// write selects and a wrapping accepted-write counter.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   reset      - synchronous, active-high; clears all state
//   we_onehot  - one-hot write select from the upstream address decoder
//   wr_data    - data written to the selected register
//   rd_en      - read request for both read ports
//   rd_addr_a  - read index, port A
//   rd_addr_b  - read index, port B
//   rd_data_a  - registered read data, port A
//   rd_data_b  - registered read data, port B
//   rd_valid   - one-cycle pulse when rd_data_a/rd_data_b are freshly loaded
//   wr_err     - sticky flag, set by a write select with two or more bits set
//   wr_count   - number of accepted writes, wraps to zero
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a read of the register accepted for
//                       write at the same edge returns the new wr_data
//                       (write-first); otherwise the old contents (read-first).
module register_file_8x #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        we_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic              wr_err,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned NUM_REGS = 8;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wr_none;
    logic              wr_multi;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;

    // Classify the write select: x & (x-1) clears the lowest set bit, so a
    // nonzero result means more than one bit was set.
    always_comb begin
        wr_none  = (we_onehot == 8'h00);
        wr_multi = ((we_onehot & (we_onehot - 8'd1)) != 8'h00);
        wr_ok    = !wr_none && !wr_multi;
    end

    // Read-port next values; only an accepted write may be forwarded.
    always_comb begin
        rd_next_a = regs[rd_addr_a];
        rd_next_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && we_onehot[rd_addr_a]) begin
            rd_next_a = wr_data;
        end
        if (wr_ok && we_onehot[rd_addr_b]) begin
            rd_next_b = wr_data;
        end
`endif
    end

    // Storage, status and read-port registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_err    <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (wr_ok) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (we_onehot[i]) begin
                        regs[i] <= wr_data;
                    end
                end
                wr_count <= wr_count + CNT_W'(1);
            end
            if (wr_multi) begin
                wr_err <= 1'b1;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= rd_next_a;
                rd_data_b <= rd_next_b;
            end
        end
    end

endmodule

// File: tb/tb_register_file_8x.sv
// tb_register_file_8x: directed-vector self-checking bench for register_file_8x.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_register_file_8x;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic [7:0]        we_onehot;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid;
    logic              wr_err;
    logic [CNT_W-1:0]  wr_count;

    int checks;
    int errors;

    register_file_8x #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .we_onehot (we_onehot),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .wr_err    (wr_err),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_onehot = 8'h00;
        rd_en     = 1'b0;
    endtask

    task automatic write_reg(input int idx, input logic [DATA_W-1:0] val);
        we_onehot = 8'(1 << idx);
        wr_data   = val;
        rd_en     = 1'b0;
        step();
        idle();
    endtask

    task automatic read_regs(input logic [2:0] a, input logic [2:0] b);
        we_onehot = 8'h00;
        rd_en     = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        step();
        idle();
    endtask

    initial begin
        logic [DATA_W-1:0] exp_fwd;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        we_onehot = 8'h00;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        #1;
        step();
        step();
        check_val("rst_rd_data_a", 32'(rd_data_a), 32'h0);
        check_val("rst_rd_data_b", 32'(rd_data_b), 32'h0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_val("rst_wr_err", 32'(wr_err), 32'h0);
        check_val("rst_wr_count", 32'(wr_count), 32'h0);
        reset = 1'b0;

        // Basic write then read of register 3.
        write_reg(3, 16'h1234);
        read_regs(3'd3, 3'd0);
        check_val("basic_rd_a", 32'(rd_data_a), 32'h1234);
        check_val("basic_valid", 32'(rd_valid), 32'h1);
        check_val("basic_count", 32'(wr_count), 32'h1);
        check_val("basic_err", 32'(wr_err), 32'h0);

        // Read data holds while rd_en is low.
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("hold_rd_a", 32'(rd_data_a), 32'h1234);
            check_val("hold_valid", 32'(rd_valid), 32'h0);
        end

        // Fill all registers from a clean reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_reg(i, 16'(16'hA000 + i));
        end
        read_regs(3'd0, 3'd7);
        check_val("fill_rd_a_0", 32'(rd_data_a), 32'hA000);
        check_val("fill_rd_b_7", 32'(rd_data_b), 32'hA007);
        read_regs(3'd3, 3'd3);
        check_val("same_addr_a", 32'(rd_data_a), 32'hA003);
        check_val("same_addr_b", 32'(rd_data_b), 32'hA003);
        check_val("fill_count", 32'(wr_count), 32'h8);

        // An all-zero select is a no-op.
        we_onehot = 8'h00;
        wr_data   = 16'h5A5A;
        step();
        check_val("nowr_count", 32'(wr_count), 32'h8);
        check_val("nowr_err", 32'(wr_err), 32'h0);

        // Multi-hot select is rejected, flagged, and never forwarded.
        write_reg(2, 16'h0002);
        we_onehot = 8'h05;
        wr_data   = 16'hFFFF;
        rd_en     = 1'b1;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd0;
        step();
        idle();
        check_val("multi_err", 32'(wr_err), 32'h1);
        check_val("multi_count", 32'(wr_count), 32'h9);
        check_val("multi_nofwd_a", 32'(rd_data_a), 32'h0002);
        check_val("multi_nofwd_b", 32'(rd_data_b), 32'hA000);
        step();
        check_val("multi_err_sticky", 32'(wr_err), 32'h1);
        read_regs(3'd2, 3'd0);
        check_val("multi_reg2", 32'(rd_data_a), 32'h0002);
        check_val("multi_reg0", 32'(rd_data_b), 32'hA000);

        // Same-cycle write and read of one register.
        write_reg(5, 16'h0055);
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 16'h00AA;
`else
        exp_fwd = 16'h0055;
`endif
        we_onehot = 8'h20;
        wr_data   = 16'h00AA;
        rd_en     = 1'b1;
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd5;
        step();
        idle();
        check_val("rw_same_a", 32'(rd_data_a), 32'(exp_fwd));
        check_val("rw_same_b", 32'(rd_data_b), 32'(exp_fwd));
        check_val("rw_count", 32'(wr_count), 32'hB);
        read_regs(3'd5, 3'd1);
        check_val("rw_next_a", 32'(rd_data_a), 32'h00AA);

        // Reset clears the sticky error.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rst_clr_err", 32'(wr_err), 32'h0);
        check_val("rst_clr_count", 32'(wr_count), 32'h0);

        // Counter wraps after 256 accepted writes.
        for (int i = 0; i < 256; i++) begin
            we_onehot = 8'(1 << (i % 8));
            wr_data   = 16'(i);
            step();
            if (i == 254) begin
                check_val("cnt_255", 32'(wr_count), 32'hFF);
            end
        end
        idle();
        check_val("cnt_wrap", 32'(wr_count), 32'h0);
        check_val("cnt_wrap_err", 32'(wr_err), 32'h0);

        // Reset beats a write and a read at the same edge.
        reset     = 1'b1;
        we_onehot = 8'h02;
        wr_data   = 16'hBEEF;
        rd_en     = 1'b1;
        rd_addr_a = 3'd1;
        step();
        check_val("rstw_valid", 32'(rd_valid), 32'h0);
        check_val("rstw_count", 32'(wr_count), 32'h0);
        check_val("rstw_err", 32'(wr_err), 32'h0);

        // First edge after reset: write reg 4 and read reg 1 together.
        reset     = 1'b0;
        we_onehot = 8'h10;
        wr_data   = 16'h4444;
        rd_en     = 1'b1;
        rd_addr_a = 3'd1;
        rd_addr_b = 3'd7;
        step();
        idle();
        check_val("rstw_reg1", 32'(rd_data_a), 32'h0000);
        check_val("rstw_reg7", 32'(rd_data_b), 32'h0000);
        check_val("post_rst_valid", 32'(rd_valid), 32'h1);
        read_regs(3'd4, 3'd1);
        check_val("post_rst_reg4", 32'(rd_data_a), 32'h4444);
        check_val("post_rst_count", 32'(wr_count), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_8x.md
REGISTER_FILE_8X -- requirements
Module: register_file_8x

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of each register and of the data ports.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the accepted-write counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port we_onehot, input, 8, the one-hot write select driven by the upstream 3-to-8 write-address decoder (bit i selects register i).
REQ-006 The block SHALL have port wr_data, input, DATA_W, the data written to the selected register.
REQ-007 The block SHALL have port rd_en, input, 1, which requests a read on both read ports.
REQ-008 The block SHALL have ports rd_addr_a and rd_addr_b, input, 3 each, the read register indices.
REQ-009 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, registered read data.
REQ-010 The block SHALL have port rd_valid, output, 1, high for one cycle when rd_data_a/rd_data_b carry new data.
REQ-011 The block SHALL have port wr_err, output, 1, a sticky flag for a rejected write.
REQ-012 The block SHALL have port wr_count, output, CNT_W, the number of accepted writes.

Function
REQ-013 Storage SHALL be 8 registers of DATA_W bits, index 0..7.
REQ-014 At a rising edge with reset low and exactly one bit i of we_onehot set, register i SHALL load wr_data and wr_count SHALL increment by 1.
REQ-015 With we_onehot = 8'h00, no register SHALL change, and neither SHALL wr_count or wr_err.
REQ-016 With two or more bits of we_onehot set, no register SHALL change; wr_err SHALL be set to 1 at that edge and stay 1 until reset; wr_count SHALL not change.
REQ-017 wr_count SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-018 A read SHALL have 1-cycle latency: at the edge where rd_en is sampled high, rd_data_a/rd_data_b SHALL load the contents of registers rd_addr_a/rd_addr_b and rd_valid SHALL become 1.
REQ-019 At an edge where rd_en is sampled low, rd_valid SHALL become 0 and rd_data_a/rd_data_b SHALL hold their previous values.
REQ-020 rd_addr_a and rd_addr_b SHALL be allowed to be equal, and both ports SHALL then return the same value.
REQ-021 Reads and writes SHALL be allowed in the same cycle; the value returned when a read address matches the register accepted for write in that cycle is set by REQ-026/REQ-027.
REQ-022 A rejected write (REQ-016) SHALL never be forwarded to a read port, in either configuration.

Reset
REQ-023 At an edge with reset high, all 8 registers, rd_data_a, rd_data_b, rd_valid, wr_err and wr_count SHALL become 0.
REQ-024 Reset SHALL take priority over any write or read at the same edge; that write SHALL be discarded and that read SHALL produce no rd_valid.
REQ-025 At the first edge after reset goes low, writes and reads SHALL operate normally with no idle cycles.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, when a read and an accepted write at the same edge target the same register, the read port SHALL return the wr_data of that cycle (write-first).
REQ-027 With REGFILE_BYPASS_EN not defined, that read SHALL return the register's value before the write (read-first), and the new value SHALL be visible from the next read.

Verification
REQ-028 Reset, then write 16'h1234 with we_onehot=8'h08, then rd_en=1, rd_addr_a=3 -> one cycle later rd_data_a=16'h1234, rd_valid=1, wr_count=1, wr_err=0.
REQ-029 Write each register i with 16'hA000+i using we_onehot=1<<i, then read pairs (0,7),(3,3) -> 16'hA000/16'hA007, then 16'hA003 on both ports; wr_count=8.
REQ-030 Register 2 holds 16'h0002; drive we_onehot=8'h05 with wr_data=16'hFFFF -> wr_err=1 and stays 1; registers 0 and 2 unchanged; wr_count unchanged; a later read of 2 returns 16'h0002.
REQ-031 Register 5 holds 16'h0055; in one cycle write 16'h00AA with we_onehot=8'h20 and read rd_addr_a=5 -> rd_data_a=16'h00AA with REGFILE_BYPASS_EN, 16'h0055 without it; the next read returns 16'h00AA in both builds.
REQ-032 With CNT_W=8, perform 256 accepted writes -> wr_count returns to 8'h00; assert reset in the same cycle as a write of 16'hBEEF to register 1 -> register 1 reads 16'h0000, and wr_count and wr_err are 0.
REQ-033 With rd_en low for 3 cycles after a read returned 16'h1234 -> rd_data_a holds 16'h1234 and rd_valid=0 for all 3 cycles.
